// File: rtl/nonce_reporter_pkg.sv
// Shared miner-side definitions for the nonce reporter:
// widths, default compact target, serializer states, nBits expansion.
package nonce_reporter_pkg;

    localparam int HASH_W  = 256;
    localparam int NONCE_W = 32;

    localparam logic [31:0] DEF_BITS = 32'h1d00ffff;

    typedef enum logic {
        SER_IDLE = 1'b0,
        SER_SEND = 1'b1
    } ser_state_t;

    // Compact {E, sign, M} to 256-bit target; overflow saturates high.
    function automatic logic [HASH_W-1:0] expand_bits(
        input logic [31:0] b
    );
        logic [7:0]   e;
        logic [22:0]  m;
        logic [1:0]   rs;
        logic [4:0]   ls;
        logic [287:0] w;
        logic [255:0] t;
        e  = b[31:24];
        m  = b[22:0];
        rs = '0;
        ls = '0;
        w  = '0;
        t  = '0;
        if (b[23] || m == '0) begin
            t = '0;
        end else if (e <= 8'd3) begin
            rs = 2'(8'd3 - e);
            t  = {233'd0, m} >> {rs, 3'b000};
        end else if (e >= 8'd35) begin
            t = '1;
        end else begin
            ls = 5'(e - 8'd3);
            w  = {265'd0, m} << {ls, 3'b000};
            t  = (|w[287:256]) ? '1 : w[255:0];
        end
        return t;
    endfunction

endpackage

// File: rtl/nonce_fifo.sv
// Synchronous FIFO for golden nonces; pointers wrap modulo DEPTH,
// the level counter separates full from empty.
module nonce_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 8
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr;
    logic [AW-1:0]    r_rd;
    logic [AW:0]      r_level;
    logic             w_do_push;
    logic             w_do_pop;

    assign full      = (r_level == (AW+1)'(DEPTH));
    assign empty     = (r_level == '0);
    assign level     = r_level;
    assign dout      = r_mem[r_rd];
    assign w_do_push = push && !full;
    assign w_do_pop  = pop && !empty;

    always_ff @(posedge clock) begin
        if (w_do_push) begin
            r_mem[r_wr] <= din;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_level <= '0;
        end else begin
            if (w_do_push) begin
                r_wr <= r_wr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd <= r_rd + 1'b1;
            end
            r_level <= r_level
                     + {{AW{1'b0}}, w_do_push}
                     - {{AW{1'b0}}, w_do_pop};
        end
    end

endmodule

// File: rtl/nonce_reporter.sv
// Checks miner hashes against the compact target, queues golden
// nonces and streams them MSB-first as bytes over valid/ready.
module nonce_reporter
    import nonce_reporter_pkg::*;
#(
    parameter int          FIFO_DEPTH = 8,
    parameter int          CNT_W      = 16,
    parameter logic [31:0] RESET_BITS = DEF_BITS
) (
    input  logic                        clock,
    input  logic                        reset_n,
    input  logic                        hash_valid,
    input  logic [HASH_W-1:0]           hash,
    input  logic [NONCE_W-1:0]          nonce,
    input  logic                        bits_load,
    input  logic [31:0]                 bits_in,
    output logic [7:0]                  tx_data,
    output logic                        tx_valid,
    input  logic                        tx_ready,
    output logic [CNT_W-1:0]            hit_count,
    output logic [CNT_W-1:0]            drop_count,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level
);

    logic [HASH_W-1:0]  r_target;
    logic               r_s1_valid;
    logic [HASH_W-1:0]  r_s1_val;
    logic [NONCE_W-1:0] r_s1_nonce;
    logic [CNT_W-1:0]   r_hits;
    logic [CNT_W-1:0]   r_drops;
    ser_state_t         r_state;
    logic [31:0]        r_shift;
    logic [1:0]         r_idx;
    logic [7:0]         r_tx_data;
    logic               r_tx_valid;

    logic [HASH_W-1:0]  w_val;
    logic               w_win;
    logic               w_push;
    logic               w_pop;
    logic               w_full;
    logic               w_empty;
    logic               w_hs;
    logic [31:0]        w_dout;

    // Miner emits word 0 first; compare as a little-endian number.
    always_comb begin
        w_val = '0;
        for (int k = 0; k < 32; k++) begin
            w_val[8*(31-k) +: 8] = hash[8*k +: 8];
        end
    end

    assign w_win  = r_s1_valid && (r_s1_val <= r_target);
    assign w_push = w_win && !w_full;
    assign w_hs   = r_tx_valid && tx_ready;
    assign w_pop  = !w_empty
                 && ((r_state == SER_IDLE)
                  || (w_hs && r_idx == 2'd3));

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_target   <= expand_bits(RESET_BITS);
            r_s1_valid <= 1'b0;
            r_s1_val   <= '0;
            r_s1_nonce <= '0;
        end else begin
            if (bits_load) begin
                r_target <= expand_bits(bits_in);
            end
            r_s1_valid <= hash_valid;
            r_s1_val   <= w_val;
            r_s1_nonce <= nonce;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_hits  <= '0;
            r_drops <= '0;
        end else if (w_win) begin
            if (r_hits != '1) begin
                r_hits <= r_hits + 1'b1;
            end
            if (w_full && r_drops != '1) begin
                r_drops <= r_drops + 1'b1;
            end
        end
    end

    nonce_fifo #(
        .WIDTH (NONCE_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock   (clock),
        .reset_n (reset_n),
        .push    (w_push),
        .pop     (w_pop),
        .din     (r_s1_nonce),
        .dout    (w_dout),
        .full    (w_full),
        .empty   (w_empty),
        .level   (fifo_level)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= SER_IDLE;
            r_shift    <= '0;
            r_idx      <= '0;
            r_tx_data  <= '0;
            r_tx_valid <= 1'b0;
        end else begin
            unique case (r_state)
                SER_IDLE: begin
                    if (!w_empty) begin
                        r_shift    <= w_dout;
                        r_tx_data  <= w_dout[31:24];
                        r_idx      <= '0;
                        r_tx_valid <= 1'b1;
                        r_state    <= SER_SEND;
                    end
                end
                SER_SEND: begin
                    if (w_hs) begin
                        if (r_idx != 2'd3) begin
                            r_idx     <= r_idx + 1'b1;
                            r_shift   <= {r_shift[23:0], 8'h00};
                            r_tx_data <= r_shift[23:16];
                        end else if (!w_empty) begin
                            r_shift   <= w_dout;
                            r_tx_data <= w_dout[31:24];
                            r_idx     <= '0;
                        end else begin
                            r_tx_valid <= 1'b0;
                            r_state    <= SER_IDLE;
                        end
                    end
                end
                default: r_state <= SER_IDLE;
            endcase
        end
    end

    assign tx_data    = r_tx_data;
    assign tx_valid   = r_tx_valid;
    assign hit_count  = r_hits;
    assign drop_count = r_drops;

endmodule

// File: tb/tb_nonce_reporter.sv
// Randomized + directed bench for nonce_reporter against a
// queue-based behavioural model of the reporter.
module tb_nonce_reporter;

    localparam int DEPTH = 8;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         hash_valid = 1'b0;
    logic [255:0] hash = '0;
    logic [31:0]  nonce = '0;
    logic         bits_load = 1'b0;
    logic [31:0]  bits_in = '0;
    logic         tx_ready = 1'b1;

    logic [7:0]   tx_data;
    logic         tx_valid;
    logic [15:0]  hit_count;
    logic [15:0]  drop_count;
    logic [3:0]   fifo_level;

    logic [7:0]   tx_data4;
    logic         tx_valid4;
    logic [3:0]   hit4;
    logic [3:0]   drop4;
    logic [3:0]   level4;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int first_v = -1;
    logic [7:0] cap[$];

    nonce_reporter #(.FIFO_DEPTH(DEPTH), .CNT_W(16)) dut (
        .clock(clk), .reset_n(reset_n),
        .hash_valid(hash_valid), .hash(hash), .nonce(nonce),
        .bits_load(bits_load), .bits_in(bits_in),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .hit_count(hit_count), .drop_count(drop_count),
        .fifo_level(fifo_level)
    );

    nonce_reporter #(.FIFO_DEPTH(DEPTH), .CNT_W(4)) dut4 (
        .clock(clk), .reset_n(reset_n),
        .hash_valid(hash_valid), .hash(hash), .nonce(nonce),
        .bits_load(bits_load), .bits_in(bits_in),
        .tx_data(tx_data4), .tx_valid(tx_valid4), .tx_ready(tx_ready),
        .hit_count(hit4), .drop_count(drop4),
        .fifo_level(level4)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [255:0] act,
                         input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Target straight from the nBits definition, using wide arithmetic.
    function automatic logic [255:0] model_target(input logic [31:0] b);
        int e;
        logic [22:0]  m;
        logic [511:0] wide;
        longint q;
        e = int'(b[31:24]);
        m = b[22:0];
        if (b[23] || m == 0) return '0;
        if (e <= 3) begin
            q = longint'(m) / (longint'(1) << (8 * (3 - e)));
            return 256'(q);
        end
        if (e >= 67) return '1;
        wide = 512'(m) << (8 * (e - 3));
        if (wide[511:256] != 0) return '1;
        return wide[255:0];
    endfunction

    // Model state
    logic [255:0] m_tgt;
    logic         m_s1v;
    logic [255:0] m_s1V;
    logic [31:0]  m_s1n;
    logic [31:0]  mq[$];
    logic [31:0]  m_cur;
    int           m_cnt;
    int           m_hits;
    int           m_drops;
    logic         m_win;
    logic         m_full;
    logic         m_pop;

    task automatic mdl_reset();
        m_tgt   = model_target(32'h1d00ffff);
        m_s1v   = 1'b0;
        m_s1V   = '0;
        m_s1n   = '0;
        mq.delete();
        m_cur   = '0;
        m_cnt   = 0;
        m_hits  = 0;
        m_drops = 0;
    endtask

    always @(posedge clk) cyc++;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mdl_reset();
        end else begin
            m_win  = m_s1v && (m_s1V <= m_tgt);
            m_full = (mq.size() == DEPTH);
            m_pop  = (mq.size() > 0)
                  && (m_cnt == 0 || (m_cnt == 1 && tx_ready));
            if (m_cnt > 0 && tx_ready) m_cnt--;
            if (m_pop) begin
                m_cur = mq.pop_front();
                m_cnt = 4;
            end
            if (m_win) begin
                m_hits++;
                if (!m_full) mq.push_back(m_s1n);
                else m_drops++;
            end
            m_s1v = hash_valid;
            m_s1V = {<<8{hash}};
            m_s1n = nonce;
            if (bits_load) m_tgt = model_target(bits_in);
        end
    end

    function automatic int sat(input int v, input int w);
        int mx;
        mx = (1 << w) - 1;
        return (v > mx) ? mx : v;
    endfunction

    // Single per-cycle comparison of both instances with the model.
    always @(negedge clk) begin
        check("tx_valid", 256'(tx_valid), 256'(m_cnt > 0));
        check("tx_valid4", 256'(tx_valid4), 256'(m_cnt > 0));
        if (m_cnt > 0) begin
            check("tx_data", 256'(tx_data),
                  256'((m_cur >> (8 * (m_cnt - 1))) & 32'hff));
            check("tx_data4", 256'(tx_data4), 256'(tx_data));
        end
        check("hit_count", 256'(hit_count), 256'(sat(m_hits, 16)));
        check("drop_count", 256'(drop_count), 256'(sat(m_drops, 16)));
        check("fifo_level", 256'(fifo_level), 256'(mq.size()));
        check("hit4", 256'(hit4), 256'(sat(m_hits, 4)));
        check("drop4", 256'(drop4), 256'(sat(m_drops, 4)));
        check("level4", 256'(level4), 256'(mq.size()));
        if (tx_valid && first_v < 0) first_v = cyc;
        if (tx_valid && tx_ready) cap.push_back(tx_data);
    end

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [255:0] h, input logic [31:0] n);
        hash_valid = 1'b1;
        hash = h;
        nonce = n;
        tick();
        hash_valid = 1'b0;
    endtask

    task automatic load_bits(input logic [31:0] b);
        bits_load = 1'b1;
        bits_in = b;
        tick();
        bits_load = 1'b0;
    endtask

    logic [255:0] h2;
    logic [255:0] rh;
    int base;
    int n0;

    initial begin
        mdl_reset();
        check("pin_diff1", model_target(32'h1d00ffff),
              {32'h0, 16'hffff, 208'h0});
        check("pin_sign", model_target(32'h1d80ffff), 256'h0);
        check("pin_e3", model_target(32'h03123456), 256'h123456);
        check("pin_e2", model_target(32'h02123456), 256'h1234);
        check("pin_ovf", model_target(32'h23010000), {256{1'b1}});
        check("pin_e34", model_target(32'h22000001), 256'h1 << 248);

        tick(3);
        check("rst_tx_valid", 256'(tx_valid), 256'h0);
        check("rst_tx_data", 256'(tx_data), 256'h0);
        check("rst_hits", 256'(hit_count), 256'h0);
        check("rst_level", 256'(fifo_level), 256'h0);
        reset_n = 1'b1;
        tick(2);

        // Test 1: zero hash with default target, latency and byte order
        tx_ready = 1'b1;
        first_v = -1;
        base = cap.size();
        n0 = cyc;
        send(256'h0, 32'hDEADBEEF);
        tick(10);
        check("t1_latency", 256'(first_v), 256'(n0 + 3));
        check("t1_hits", 256'(hit_count), 256'd1);
        check("t1_nbytes", 256'(cap.size() - base), 256'd4);
        if (cap.size() >= base + 4) begin
            check("t1_b0", 256'(cap[base]), 256'hDE);
            check("t1_b1", 256'(cap[base+1]), 256'hAD);
            check("t1_b2", 256'(cap[base+2]), 256'hBE);
            check("t1_b3", 256'(cap[base+3]), 256'hEF);
        end

        // Test 2: V equal to target wins, target+1 loses
        h2 = '0;
        h2[47:32] = 16'hFFFF;
        send(h2, 32'h11111111);
        tick(8);
        check("t2_eq_hit", 256'(hit_count), 256'd2);
        h2[255:248] = 8'h01;
        first_v = -1;
        send(h2, 32'h22222222);
        tick(8);
        check("t2_plus1_miss", 256'(hit_count), 256'd2);
        check("t2_no_tx", 256'(first_v), 256'(-1));

        // Test 3: high-valued hash, then wider and zero targets
        h2 = '0;
        h2[7:0] = 8'h01;
        send(h2, 32'h33333333);
        tick(6);
        check("t3_miss", 256'(hit_count), 256'd2);
        load_bits(32'h2100ffff);
        send(h2, 32'h44444444);
        tick(6);
        check("t3_wide_hit", 256'(hit_count), 256'd3);
        load_bits(32'h1d80ffff);
        send(256'h0, 32'h55555555);
        tick(6);
        check("t3_sign_hit", 256'(hit_count), 256'd4);
        load_bits(32'h1d00ffff);
        tick(10);

        // Test 4: overflow the queue while the link is stalled
        tx_ready = 1'b0;
        base = cap.size();
        for (int i = 0; i < DEPTH + 3; i++) begin
            send(256'h0, 32'hA0000000 + i);
        end
        tick(5);
        check("t4_level", 256'(fifo_level), 256'(DEPTH));
        check("t4_drops", 256'(drop_count), 256'd2);
        check("t4_hits", 256'(hit_count), 256'd15);
        tx_ready = 1'b1;
        tick(45);
        check("t4_nbytes", 256'(cap.size() - base), 256'd36);
        if (cap.size() >= base + 36) begin
            check("t4_first", 256'(cap[base]), 256'hA0);
            check("t4_last", 256'(cap[base+35]), 256'h08);
        end
        check("t4_drained", 256'(fifo_level), 256'd0);

        // Test 5: random hashes, targets and backpressure
        for (int c = 0; c < 600; c++) begin
            tx_ready = ($urandom % 3) != 0;
            hash_valid = ($urandom % 5) < 3;
            for (int w = 0; w < 8; w++) rh[32*w +: 32] = $urandom;
            if ($urandom % 2) rh[31:0] = '0;
            if ($urandom % 4 == 0) rh[63:0] = '0;
            hash = rh;
            nonce = $urandom;
            bits_load = ($urandom % 40) == 0;
            case ($urandom % 6)
                0: bits_in = 32'h1d00ffff;
                1: bits_in = 32'h2100ffff;
                2: bits_in = 32'h1d80ffff;
                3: bits_in = 32'h03123456;
                4: bits_in = 32'h20ffffff;
                default: bits_in = {8'($urandom_range(0, 34)),
                                    1'($urandom % 2), 23'($urandom)};
            endcase
            tick();
        end
        hash_valid = 1'b0;
        bits_load = 1'b0;
        tx_ready = 1'b1;
        tick(60);

        // Reset in the middle of a word
        for (int i = 0; i < 3; i++) send(256'h0, 32'hC0DE0000 + i);
        base = cap.size();
        for (int i = 0; i < 60 && cap.size() < base + 2; i++) tick();
        check("t5_two_bytes", 256'(cap.size() >= base + 2), 256'd1);
        reset_n = 1'b0;
        #1;
        check("t5_rst_valid", 256'(tx_valid), 256'h0);
        check("t5_rst_level", 256'(fifo_level), 256'h0);
        tick(2);
        reset_n = 1'b1;
        tick(2);

        // Test 6: saturation of the narrow counter
        for (int i = 0; i < 20; i++) send(256'h0, 32'hF000 + i);
        tick(10);
        check("t6_hit4_sat", 256'(hit4), 256'hF);
        check("t6_hit16", 256'(hit_count), 256'd20);
        tick(120);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
